// File: rtl/div_product_rebuild_if.sv
// Operand/result bundle for div_product_rebuild: request side (start, q, d, r)
// and result side (busy, done, p, rem_ok).
interface div_product_rebuild_if #(
    parameter int W = 16
);
    logic             start;
    logic [W-1:0]     q;
    logic [W-1:0]     d;
    logic [W-1:0]     r;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   p;
    logic             rem_ok;

    modport master (output start, q, d, r, input busy, done, p, rem_ok);
    modport slave  (input start, q, d, r, output busy, done, p, rem_ok);
endinterface

// File: rtl/div_product_rebuild.sv
// Rebuilds the divider's dividend as p = q*d + r with a shift-add multiplier whose
// accumulator is preloaded with r. Optional DIV_REBUILD_EARLY_TERM_EN stops once q is exhausted.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one shift-add iteration per edge, busy high
// DONE  | one-cycle done pulse, p valid
module div_product_rebuild #(
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    div_product_rebuild_if.slave bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [2*W-1:0]   acc, mcand, acc_sum, p_q;
    logic [W-1:0]     mplier;
    logic [CW-1:0]    cnt;
    logic             rem_ok_q;
    logic             accept, last_iter;

    assign accept  = (state == S_IDLE) && bus.start;
    assign acc_sum = acc + (mplier[0] ? mcand : '0);

`ifdef DIV_REBUILD_EARLY_TERM_EN
    // Remaining multiplier bits all zero means no further additions can occur.
    assign last_iter = (mplier[W-1:1] == '0) || (cnt == CW'(W - 1));
`else
    assign last_iter = (cnt == CW'(W - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_RUN;
            S_RUN:   if (last_iter) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            p_q      <= '0;
            rem_ok_q <= 1'b0;
        end else if (accept) begin
            acc      <= {{W{1'b0}}, bus.r};
            mcand    <= {{W{1'b0}}, bus.d};
            mplier   <= bus.q;
            cnt      <= '0;
            rem_ok_q <= (bus.r < bus.d);
        end else if (state == S_RUN) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last_iter) begin
                p_q <= acc_sum;
            end
        end
    end

    assign bus.busy   = (state == S_RUN);
    assign bus.done   = (state == S_DONE);
    assign bus.p      = p_q;
    assign bus.rem_ok = rem_ok_q;
endmodule
